// File: rtl/ldtu_ser_pkg.sv
// ldtu_ser_pkg: shared defaults, bit-order type and lane slicing helper
// for the multi-lane LiTE-DTU serializer.
package ldtu_ser_pkg;

    localparam int DEF_NLANES = 4;
    localparam int DEF_WORD_W = 32;
    localparam logic [31:0] DEF_TRAIN_PATTERN = 32'hA5A5_5A5A;

    typedef enum logic {
        BO_LSB_FIRST = 1'b0,
        BO_MSB_FIRST = 1'b1
    } bit_order_e;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/ldtu_ser_lane.sv
// ldtu_ser_lane: one serial lane, loads a word on the boundary and shifts
// it toward the output end, zero-filling behind it.
module ldtu_ser_lane
    import ldtu_ser_pkg::*;
#(
    parameter int         WORD_W = DEF_WORD_W,
    parameter bit_order_e ORDER  = BO_MSB_FIRST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic              dout
);

    logic [WORD_W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = load ? din : shift ? (ORDER == BO_MSB_FIRST ? sr_q << 1 : sr_q >> 1) : sr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign dout = (ORDER == BO_MSB_FIRST) ? sr_q[WORD_W-1] : sr_q[0];

endmodule

// File: rtl/ldtu_serializer_nlane.sv
// ldtu_serializer_nlane: NLANES word-to-bit serializer sharing one bit counter,
// handshake, word counter and boundary-sampled enable/training controls.
module ldtu_serializer_nlane
    import ldtu_ser_pkg::*;
#(
    parameter int          NLANES        = DEF_NLANES,
    parameter int          WORD_W        = DEF_WORD_W,
    parameter int          MSB_FIRST     = 1,
    parameter logic [31:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int          CNT_W         = $clog2(WORD_W)
) (
    input  logic                     CLK_SRL,
    input  logic                     RST,
    input  logic [NLANES*WORD_W-1:0] DataIn,
    input  logic [NLANES-1:0]        LANE_EN,
    input  logic                     TRAIN_MODE,
    output logic                     handshake,
    output logic [NLANES-1:0]        DataOut,
    output logic [15:0]              word_count,
    output logic                     train_active
);

    localparam logic [WORD_W-1:0] TRAIN_WORD = WORD_W'(TRAIN_PATTERN);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE    = CNT_W'(WORD_W - 2);
    localparam bit_order_e        ORDER      = (MSB_FIRST != 0) ? BO_MSB_FIRST : BO_LSB_FIRST;

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              handshake_q, handshake_d;
    logic [15:0]       word_count_q, word_count_d;
    logic [NLANES-1:0] en_q, en_d;
    logic              train_q, train_d;

    // handshake_q is high exactly in the last-bit cycle, so it marks the boundary edge
    always_comb begin
        bit_cnt_d    = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
        handshake_d  = bit_cnt_q == CNT_PRE;
        word_count_d = word_count_q + {15'd0, handshake_q};
        en_d         = handshake_q ? LANE_EN : en_q;
        train_d      = handshake_q ? TRAIN_MODE : train_q;
    end

    always_ff @(posedge CLK_SRL or posedge RST) begin
        if (RST) begin
            bit_cnt_q    <= '0;
            handshake_q  <= 1'b0;
            word_count_q <= '0;
            en_q         <= '0;
            train_q      <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            handshake_q  <= handshake_d;
            word_count_q <= word_count_d;
            en_q         <= en_d;
            train_q      <= train_d;
        end
    end

    assign handshake    = handshake_q;
    assign word_count   = word_count_q;
    assign train_active = train_q;

    // Disabled lanes load zero and then hold, so they stay quiet for the whole word
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        logic [WORD_W-1:0] next_word;
        always_comb begin
            next_word = !LANE_EN[i] ? '0 : TRAIN_MODE ? TRAIN_WORD : DataIn[lane_lsb(i, WORD_W) +: WORD_W];
        end
        ldtu_ser_lane #(
            .WORD_W(WORD_W),
            .ORDER (ORDER)
        ) u_lane (
            .clk  (CLK_SRL),
            .rst  (RST),
            .load (handshake_q),
            .shift(en_q[i]),
            .din  (next_word),
            .dout (DataOut[i])
        );
    end

endmodule
